// File: rtl/sort_result_checker_if.sv
// ---------------------------------------------------------------------------
// sort_result_checker_if
// Bundles the checker's handshake, memory read ports and result bus.
//   start            harness -> checker, single-cycle start pulse
//   rom_addr/ram_addr checker -> memories, read addresses (always equal)
//   rom_data/ram_data memories -> checker, read data (two's complement)
//   busy/done/pass   run status
//   order_err_cnt, first_err_valid, first_err_idx  ordering statistics
//   sum_rom/sum_ram  signed sums over all entries
//   cycle_cnt        busy cycles of the last run
// The checker connects through the master modport; the harness/memory
// side connects through the slave modport.
// ---------------------------------------------------------------------------
interface sort_result_checker_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic                start;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_data;
    logic                busy;
    logic                done;
    logic                pass;
    logic [7:0]          order_err_cnt;
    logic                first_err_valid;
    logic [ADDR_W-1:0]   first_err_idx;
    logic [DATA_W+7:0]   sum_rom;
    logic [DATA_W+7:0]   sum_ram;
    logic [19:0]         cycle_cnt;

    modport master (
        input  start, rom_data, ram_data,
        output rom_addr, ram_addr, busy, done, pass, order_err_cnt,
               first_err_valid, first_err_idx, sum_rom, sum_ram, cycle_cnt
    );

    modport slave (
        output start, rom_data, ram_data,
        input  rom_addr, ram_addr, busy, done, pass, order_err_cnt,
               first_err_valid, first_err_idx, sum_rom, sum_ram, cycle_cnt
    );
endinterface

// File: rtl/sort_result_checker.sv
// ---------------------------------------------------------------------------
// sort_result_checker
// Reads the verify RAM and the original test ROM back in lockstep, one
// address per cycle, and checks that the RAM is signed non-decreasing and
// that both memories sum to the same value.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sort_result_checker_if.master (start, memory read ports, results)
// Parameters: DEPTH entries checked, ADDR_W address width, DATA_W data
// width, RD_LAT memory read latency (1..4, same for ROM and RAM).
// ---------------------------------------------------------------------------
module sort_result_checker #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sort_result_checker_if.master bus
);
    localparam int SUM_W = DATA_W + 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W-1:0]         smp_idx_q;
    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic                      busy_q, done_q, pass_q;
    logic                      have_prev_q;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic                      first_err_valid_q, first_err_valid_d;
    logic [ADDR_W-1:0]         first_err_idx_q, first_err_idx_d;
    logic signed [SUM_W-1:0]   sum_rom_q, sum_rom_d;
    logic signed [SUM_W-1:0]   sum_ram_q, sum_ram_d;
    logic [19:0]               cyc_q;
    logic signed [DATA_W-1:0]  prev_q;
    logic signed [DATA_W-1:0]  rom_s, ram_s;
    logic                      smp_vld, order_err;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{8{v[DATA_W-1]}}, v};
    endfunction

    assign rom_s     = bus.rom_data;
    assign ram_s     = bus.ram_data;
    // The last stage of the issue pipe marks the cycle the read data belongs
    // to an issued address; the pipe is the only link between address and data.
    assign smp_vld   = vld_q[RD_LAT-1];
    assign order_err = smp_vld && have_prev_q && (ram_s < prev_q);

    always_comb begin
        vld_d    = '0;
        vld_d[0] = (state_q == S_ISSUE);
        for (int j = 1; j < RD_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
        end

        sum_rom_d = sum_rom_q;
        sum_ram_d = sum_ram_q;
        if (smp_vld) begin
            sum_rom_d = sum_rom_q + sext(rom_s);
            sum_ram_d = sum_ram_q + sext(ram_s);
        end

        err_cnt_d         = order_err ? sat_inc8(err_cnt_q) : err_cnt_q;
        first_err_valid_d = first_err_valid_q | order_err;
        // Index comes from the returned-sample counter, not the address bus.
        first_err_idx_d   = (order_err && !first_err_valid_q) ? smp_idx_q : first_err_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            smp_idx_q         <= '0;
            vld_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            have_prev_q       <= 1'b0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            sum_rom_q         <= '0;
            sum_ram_q         <= '0;
            cyc_q             <= '0;
        end else begin
            if (busy_q) begin
                vld_q             <= vld_d;
                cyc_q             <= sat_inc20(cyc_q);
                sum_rom_q         <= sum_rom_d;
                sum_ram_q         <= sum_ram_d;
                err_cnt_q         <= err_cnt_d;
                first_err_valid_q <= first_err_valid_d;
                first_err_idx_q   <= first_err_idx_d;
                if (smp_vld) begin
                    have_prev_q <= 1'b1;
                    smp_idx_q   <= smp_idx_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q           <= S_ISSUE;
                        addr_q            <= '0;
                        smp_idx_q         <= '0;
                        vld_q             <= '0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        have_prev_q       <= 1'b0;
                        err_cnt_q         <= '0;
                        first_err_valid_q <= 1'b0;
                        first_err_idx_q   <= '0;
                        sum_rom_q         <= '0;
                        sum_ram_q         <= '0;
                        cyc_q             <= '0;
                    end
                end
                S_ISSUE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Finish on the edge that consumes the final sample, so the
                    // results are final on the same edge done rises.
                    if (vld_d == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == 8'd0) && (sum_rom_d == sum_ram_d);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Previous RAM sample is qualified by have_prev_q and needs no reset.
    always_ff @(posedge clk) begin
        if (busy_q && smp_vld) begin
            prev_q <= ram_s;
        end
    end

    assign bus.rom_addr        = addr_q;
    assign bus.ram_addr        = addr_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.order_err_cnt   = err_cnt_q;
    assign bus.first_err_valid = first_err_valid_q;
    assign bus.first_err_idx   = first_err_idx_q;
    assign bus.sum_rom         = sum_rom_q;
    assign bus.sum_ram         = sum_ram_q;
    assign bus.cycle_cnt       = cyc_q;
endmodule

// File: tb/tb_sort_result_checker.sv
// ---------------------------------------------------------------------------
// tb_sort_result_checker
// Three checker instances (read latency 2, 1 and 4) share one ROM/RAM image
// and one start/reset. Expected results are computed from the memory image
// and queued per instance on each start; a monitor pops and compares when
// done rises.
// ---------------------------------------------------------------------------
module tb_sort_result_checker;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DATA_W-1:0] rom_mem [DEPTH];
    logic signed [DATA_W-1:0] ram_mem [DEPTH];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [7:0]  ec;
        logic        fev;
        logic [7:0]  fei;
        logic [23:0] sr;
        logic [23:0] sm;
        logic [19:0] cc;
        logic [7:0]  ra;
        logic [7:0]  wa;
    } obs_t;

    typedef struct {
        int          done_cyc;
        bit          pass;
        int          ec;
        bit          fev;
        int          fei;
        logic [23:0] sr;
        logic [23:0] sm;
        int          cc;
    } exp_t;

    obs_t obs [3];
    exp_t expq [3][$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int lat_of(input int id);
        return (id == 0) ? 2 : ((id == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        sort_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();
        logic [ADDR_W-1:0] rom_pipe [4];
        logic [ADDR_W-1:0] ram_pipe [4];

        always @(posedge clk) begin
            rom_pipe[0] <= u_if.rom_addr;
            ram_pipe[0] <= u_if.ram_addr;
            for (int k = 1; k < 4; k++) begin
                rom_pipe[k] <= rom_pipe[k-1];
                ram_pipe[k] <= ram_pipe[k-1];
            end
        end

        assign u_if.start    = start;
        assign u_if.rom_data = rom_mem[rom_pipe[L-1][5:0]];
        assign u_if.ram_data = ram_mem[ram_pipe[L-1][5:0]];

        sort_result_checker #(
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W),
            .RD_LAT(L)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (u_if)
        );

        assign obs[g] = {u_if.busy, u_if.done, u_if.pass, u_if.order_err_cnt,
                         u_if.first_err_valid, u_if.first_err_idx, u_if.sum_rom,
                         u_if.sum_ram, u_if.cycle_cnt, u_if.rom_addr, u_if.ram_addr};
    end

    task automatic chk(input string nm, input int id, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", nm, id, act, req);
        end
    endtask

    // Reference: direct evaluation of the ordering and sum rules over the image.
    function automatic exp_t model(input int id);
        exp_t   e;
        longint sr = 0;
        longint sm = 0;
        int     ec = 0;
        bit     fev = 0;
        int     fei = 0;
        for (int i = 0; i < DEPTH; i++) begin
            sr += longint'(rom_mem[i]);
            sm += longint'(ram_mem[i]);
            if (i > 0 && ram_mem[i] < ram_mem[i-1]) begin
                ec++;
                if (!fev) begin
                    fev = 1;
                    fei = i;
                end
            end
        end
        e.done_cyc = 0;
        e.ec   = (ec > 255) ? 255 : ec;
        e.fev  = fev;
        e.fei  = fei;
        e.pass = (ec == 0) && (sr == sm);
        e.sr   = sr[23:0];
        e.sm   = sm[23:0];
        e.cc   = DEPTH + lat_of(id);
        return e;
    endfunction

    // Monitor: compare on every rising edge of done.
    logic done_prev [3];
    exp_t mon_e;
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) begin
            if (obs[id].done && !done_prev[id]) begin
                if (expq[id].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done dut%0d actual=1 required=0", id);
                end else begin
                    mon_e = expq[id].pop_front();
                    chk("done_cycle", id, cyc, mon_e.done_cyc);
                    chk("pass", id, obs[id].pass, mon_e.pass);
                    chk("order_err_cnt", id, obs[id].ec, mon_e.ec);
                    chk("first_err_valid", id, obs[id].fev, mon_e.fev);
                    chk("first_err_idx", id, obs[id].fei, mon_e.fei);
                    chk("sum_rom", id, obs[id].sr, mon_e.sr);
                    chk("sum_ram", id, obs[id].sm, mon_e.sm);
                    chk("cycle_cnt", id, obs[id].cc, mon_e.cc);
                end
            end
            done_prev[id] = obs[id].done;
        end
    end

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic issue_start(input bit [2:0] accept);
        exp_t e;
        for (int id = 0; id < 3; id++) begin
            if (accept[id]) begin
                e = model(id);
                e.done_cyc = cyc + DEPTH + lat_of(id) + 1;
                expq[id].push_back(e);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_all();
        int n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL run_timeout pending=%0d required=0",
                     expq[0].size() + expq[1].size() + expq[2].size());
            for (int id = 0; id < 3; id++) expq[id].delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string nm);
        for (int id = 0; id < 3; id++) begin
            chk(nm, id, (obs[id] == '0) ? 1 : 0, 1);
        end
    endtask

    task automatic load_asc();
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = DATA_W'(i);
            ram_mem[i] = DATA_W'(i);
        end
    endtask

    task automatic load_random(input int mode);
        int q[$];
        int pick;
        for (int i = 0; i < DEPTH; i++) begin
            if (mode == 3) begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0:       rom_mem[i] = 16'sh8000;
                    1:       rom_mem[i] = 16'sh7FFF;
                    2:       rom_mem[i] = 16'sh0000;
                    default: rom_mem[i] = 16'shFFFF;
                endcase
            end else begin
                rom_mem[i] = DATA_W'($urandom);
            end
        end
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(int'(rom_mem[i]));
        q.sort();
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = DATA_W'(q[i]);
        if (mode == 0) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] = DATA_W'($urandom);
        end else if (mode == 2) begin
            pick = $urandom_range(0, DEPTH - 1);
            ram_mem[pick] = DATA_W'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int id = 0; id < 3; id++) done_prev[id] = 1'b0;
        load_asc();
        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ascending image
        issue_start(3'b111);
        wait_all();

        // Adjacent swap at 10/11
        ram_mem[10] = 16'sd11;
        ram_mem[11] = 16'sd10;
        issue_start(3'b111);
        wait_all();

        // Last entry bumped by one
        load_asc();
        ram_mem[63] = 16'sd64;
        issue_start(3'b111);
        wait_all();

        // Signed extremes
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'sd0;
        rom_mem[0]  = 16'sh8000;
        rom_mem[63] = 16'sh7FFF;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = rom_mem[i];
        issue_start(3'b111);
        wait_all();

        // Start during issue is ignored
        load_asc();
        issue_start(3'b111);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_all();

        // Restart on the first done cycle of the latency-2 instance; the
        // latency-4 instance is still busy then and must ignore it.
        ram_mem[5] = 16'sd2;
        issue_start(3'b111);
        repeat (66) @(negedge clk);
        issue_start(3'b011);
        chk("done_drop", 0, obs[0].done, 0);
        wait_all();

        // Asynchronous reset mid-issue, then a fresh run
        load_asc();
        issue_start(3'b111);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        for (int id = 0; id < 3; id++) expq[id].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset_hold");
        issue_start(3'b111);
        wait_all();

        // Randomized images
        for (int r = 0; r < 10; r++) begin
            load_random($urandom_range(0, 3));
            issue_start(3'b111);
            wait_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
